// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared constants and queue entry layout for the fetch queue.
package fetch_queue_pkg;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] BUBBLE_PC = 32'hffffffff;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        misalign;
  } fq_entry_t;
  function automatic logic is_misaligned(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// sync_fifo: DEPTH-entry synchronous FIFO with clear, combinational head and occupancy count.
module sync_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr, w_wr;
  logic [AW:0]   r_count;
  // clear rewinds both pointers, so a push in the clear cycle lands in slot 0 and becomes the head
  assign w_wr = i_clear ? '0 : r_wr;
  assign o_head = r_mem[r_rd];
  assign o_count = r_count;
  always_ff @(posedge clk)
    if (i_push) r_mem[w_wr] <= i_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
    end else begin
      r_wr <= w_wr + AW'(i_push);
      r_rd <= i_clear ? '0 : r_rd + AW'(i_pop);
      r_count <= (i_clear ? '0 : r_count - (AW+1)'(i_pop)) + (AW+1)'(i_push);
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue with variable-latency imem, hazard hold and redirect flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mb_if__jump_taken,
  input  logic [31:0] mb_if__jump_target,
  input  logic        data_hazard,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] if_id__pc,
  output logic [31:0] if_id__ins,
  output logic        if_id__ins_misalign,
  output logic        pipe_flush
);
  localparam int CW = $clog2(DEPTH) + 1;
  fq_entry_t     w_head, w_push_entry;
  logic [31:0]   r_fetch_pc, w_pc_head;
  logic [CW-1:0] w_count, w_outst, r_drop;
  logic          r_halted, w_issue, w_rsp, w_keep, w_push, w_pop, w_tgt_mis, w_empty;
  assign w_tgt_mis = is_misaligned(mb_if__jump_target);
  assign w_empty = w_count == '0;
  // queue slots are reserved at issue time, so a response always has room
  assign imem_req_valid = !rst && !r_halted && !mb_if__jump_taken &&
                          (w_outst < CW'(MAX_OUTSTANDING)) &&
                          (({1'b0, w_count} + {1'b0, w_outst}) < (CW+1)'(DEPTH));
  assign imem_req_addr = r_fetch_pc;
  assign w_issue = imem_req_valid && imem_req_ready;
  assign w_rsp = imem_rsp_valid && w_outst != '0;
  assign w_keep = w_rsp && r_drop == '0 && !mb_if__jump_taken;
  assign w_push = mb_if__jump_taken ? w_tgt_mis : w_keep;
  assign w_pop = !w_empty && !data_hazard && !mb_if__jump_taken;
  assign w_push_entry = mb_if__jump_taken ? fq_entry_t'{mb_if__jump_target, NOP, 1'b1}
                                          : fq_entry_t'{w_pc_head, imem_rsp_data, 1'b0};
  assign pipe_flush = mb_if__jump_taken;
  assign if_id__pc = w_empty ? BUBBLE_PC : w_head.pc;
  assign if_id__ins = w_empty ? NOP : w_head.ins;
  assign if_id__ins_misalign = !w_empty && w_head.misalign;
  sync_fifo #(.W($bits(fq_entry_t)), .DEPTH(DEPTH)) u_queue (
    .clk(clk), .rst(rst), .i_push(w_push), .i_pop(w_pop), .i_clear(mb_if__jump_taken),
    .i_data(w_push_entry), .o_head(w_head), .o_count(w_count)
  );
  // PCs of in-flight requests; its occupancy is the outstanding count, and stale entries pop too
  sync_fifo #(.W(32), .DEPTH(DEPTH)) u_shadow (
    .clk(clk), .rst(rst), .i_push(w_issue), .i_pop(w_rsp), .i_clear(1'b0),
    .i_data(r_fetch_pc), .o_head(w_pc_head), .o_count(w_outst)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_drop <= '0;
      r_halted <= 1'b0;
    end else if (mb_if__jump_taken) begin
      r_fetch_pc <= mb_if__jump_target;
      r_halted <= w_tgt_mis;
      r_drop <= w_outst - CW'(w_rsp);
    end else begin
      if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_rsp && r_drop != '0) r_drop <= r_drop - 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: queue-based reference model plus directed redirect vectors for fetch_queue.
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  localparam int DEPTH = 4;
  localparam int MAXO = 2;
  logic        clk = 1'b0, rst = 1'b1, jump = 1'b0, hazard = 1'b0, ready = 1'b1, rsp_valid = 1'b0;
  logic [31:0] tgt = '0, rsp_data = '0;
  logic        req_valid, flush, mis;
  logic [31:0] req_addr, pc, ins;

  fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .mb_if__jump_taken(jump), .mb_if__jump_target(tgt),
    .data_hazard(hazard), .imem_req_valid(req_valid), .imem_req_ready(ready),
    .imem_req_addr(req_addr), .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .if_id__pc(pc), .if_id__ins(ins), .if_id__ins_misalign(mis), .pipe_flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; logic [31:0] ins; logic mis;} ent_t;
  typedef struct {logic [31:0] a; bit stale;} fl_t;
  typedef struct {logic [31:0] a; int due;} im_t;
  typedef struct {logic [31:0] tgt, pc0, ins0; logic mis0; logic [31:0] pc1, ins1; logic rv;} vec_t;

  ent_t mq[$];
  fl_t  mf[$];
  im_t  imq[$];
  vec_t vt[6];
  logic [31:0] m_pc;
  bit   m_halt, seen;
  int   cyc = 0, lat_lo = 1, lat_hi = 1, last_due = 0, total = 0, bad = 0, n;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  task automatic cycle();
    bit e_valid, acc, pop;
    logic [31:0] acc_a;
    fl_t f;
    int lat;
    rsp_valid = imq.size() > 0 && imq[0].due <= cyc;
    rsp_data = rsp_valid ? imq[0].a + 32'h100 : 32'h0;
    #1;
    e_valid = !m_halt && !jump && mf.size() < MAXO && mq.size() + mf.size() < DEPTH;
    chk("req_valid", req_valid, e_valid);
    if (e_valid) chk("req_addr", req_addr, m_pc);
    chk("flush", flush, jump);
    if (mq.size() > 0) begin
      chk("pc", pc, mq[0].pc);
      chk("ins", ins, mq[0].ins);
      chk("mis", mis, mq[0].mis);
    end else begin
      chk("bubble_pc", pc, BUBBLE_PC);
      chk("bubble_ins", ins, NOP);
      chk("bubble_mis", mis, 1'b0);
    end
    pop = mq.size() > 0 && !hazard && !jump;
    if (rsp_valid && mf.size() > 0) begin
      f = mf.pop_front();
      if (!jump && !f.stale) mq.push_back(ent_t'{f.a, f.a + 32'h100, 1'b0});
    end
    if (pop) void'(mq.pop_front());
    if (jump) begin
      mq.delete();
      foreach (mf[i]) mf[i].stale = 1'b1;
      m_pc = tgt;
      m_halt = tgt[1:0] != 2'b00;
      if (m_halt) mq.push_back(ent_t'{tgt, NOP, 1'b1});
    end else if (e_valid && ready) begin
      mf.push_back(fl_t'{m_pc, 1'b0});
      m_pc += 32'd4;
    end
    acc = req_valid && ready;
    acc_a = req_addr;
    if (rsp_valid) void'(imq.pop_front());
    if (acc) begin
      lat = int'($urandom_range(lat_hi, lat_lo));
      last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      imq.push_back(im_t'{acc_a, last_due});
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    jump = 1'b0;
    hazard = 1'b0;
    rsp_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1 chk("rst_req_valid", req_valid, 1'b0);
    end
    mq.delete();
    mf.delete();
    imq.delete();
    m_pc = 32'h0;
    m_halt = 1'b0;
    last_due = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_pc", pc, BUBBLE_PC);
    chk("rst_ins", ins, NOP);
    chk("rst_mis", mis, 1'b0);
    chk("rst_flush", flush, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = vec_t'{32'h200, 32'h200, 32'h300, 1'b0, 32'h204, 32'h304, 1'b1};
    vt[1] = vec_t'{32'h202, 32'h202, NOP, 1'b1, BUBBLE_PC, NOP, 1'b0};
    vt[2] = vec_t'{32'h300, 32'h300, 32'h400, 1'b0, 32'h304, 32'h404, 1'b1};
    vt[3] = vec_t'{32'hfffffffc, 32'hfffffffc, 32'h000000fc, 1'b0, 32'h0, 32'h100, 1'b1};
    vt[4] = vec_t'{32'h401, 32'h401, NOP, 1'b1, BUBBLE_PC, NOP, 1'b0};
    vt[5] = vec_t'{32'h10, 32'h10, 32'h110, 1'b0, 32'h14, 32'h114, 1'b1};
    do_reset();
    repeat (12) cycle();
    lat_lo = 3;
    lat_hi = 3;
    hazard = 1'b1;
    repeat (8) cycle();
    hazard = 1'b0;
    repeat (6) cycle();
    foreach (vt[i]) begin
      hazard = 1'b0;
      jump = 1'b1;
      tgt = vt[i].tgt;
      cycle();
      jump = 1'b0;
      seen = 1'b0;
      n = 0;
      while (pc === BUBBLE_PC && n < 20) begin
        seen |= req_valid;
        cycle();
        n++;
      end
      chk("vec_pc0", pc, vt[i].pc0);
      chk("vec_ins0", ins, vt[i].ins0);
      chk("vec_mis0", mis, vt[i].mis0);
      seen |= req_valid;
      cycle();
      n = 0;
      while (pc === BUBBLE_PC && n < 12) begin
        seen |= req_valid;
        cycle();
        n++;
      end
      chk("vec_pc1", pc, vt[i].pc1);
      chk("vec_ins1", ins, vt[i].ins1);
      chk("vec_req_seen", seen, vt[i].rv);
    end
    lat_lo = 2;
    lat_hi = 2;
    hazard = 1'b1;
    n = 0;
    while (!(imq.size() > 0 && imq[0].due <= cyc && pc !== BUBBLE_PC) && n < 30) begin
      cycle();
      n++;
    end
    chk("same_cycle_setup", n < 30, 1'b1);
    jump = 1'b1;
    tgt = 32'h500;
    cycle();
    jump = 1'b0;
    chk("same_cycle_empty", pc, BUBBLE_PC);
    hazard = 1'b0;
    repeat (10) cycle();
    lat_lo = 1;
    lat_hi = 4;
    for (int k = 0; k < 1500; k++) begin
      if (k == 700) do_reset();
      jump = ($urandom % 24) == 0;
      case ($urandom % 8)
        0: tgt = $urandom | 32'h1;
        1: tgt = 32'hfffffff0 + 32'(($urandom % 4) * 4);
        default: tgt = {$urandom % 32'h40000000, 2'b00};
      endcase
      hazard = ($urandom % 3) == 0;
      ready = ($urandom % 4) != 0;
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
